// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (double dabble, one bit per clock).
// Optional two's-complement input; the sign is reported separately on neg.
// Digits that do not fit in DIGITS are dropped and flagged on ovf.
//
// state | meaning
// IDLE  | waiting for start; results held stable
// SHIFT | one add-3/shift step per clock, WIDTH steps in total
module bin2bcd_seq #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  signed_mode,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  mag_q, mag_d;
    logic [BW-1:0]     scr_q, scr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              sign_q, sign_d;
    logic              sticky_q, sticky_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              neg_q, neg_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;

    logic [BW-1:0]     adj;
    logic [BW-1:0]     shifted;
    logic              out_bit;

    // Add-3 correction on every digit >= 5, then the one-bit left shift of the scratch.
    always_comb begin
        adj = scr_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (scr_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
            end
        end
        out_bit = adj[BW-1];
        shifted = {adj[BW-2:0], mag_q[WIDTH-1]};
    end

    // Next-state and datapath control; a start while in SHIFT is ignored.
    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        scr_d    = scr_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        sticky_d = sticky_q;
        bcd_d    = bcd_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SHIFT;
                    sign_d   = signed_mode & bin[WIDTH-1];
                    mag_d    = bin;
                    if (signed_mode && bin[WIDTH-1]) begin
                        // Most-negative operand negates to itself, which is the correct magnitude.
                        mag_d = ~bin + {{(WIDTH-1){1'b0}}, 1'b1};
                    end
                    scr_d    = '0;
                    cnt_d    = CW'(WIDTH);
                    sticky_d = 1'b0;
                end
            end
            SHIFT: begin
                scr_d    = shifted;
                mag_d    = mag_q << 1;
                sticky_d = sticky_q | out_bit;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    bcd_d   = shifted;
                    ovf_d   = sticky_q | out_bit;
                    neg_d   = sign_q;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any conversion and clears results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mag_q    <= '0;
            scr_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            sticky_q <= 1'b0;
            bcd_q    <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mag_q    <= mag_d;
            scr_q    <= scr_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            sticky_q <= sticky_d;
            bcd_q    <= bcd_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign bcd  = bcd_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: 4-digit and 3-digit instances share all inputs.
`timescale 1ns/1ps
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_mode = 1'b0;
    logic [9:0]  bin = '0;

    logic        busy, done, neg, ovf;
    logic [15:0] bcd;
    logic        busy3, done3, neg3, ovf3;
    logic [11:0] bcd3;

    int n_cmp = 0;
    int n_bad = 0;

    bin2bcd_seq #(.WIDTH(10), .DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .neg(neg), .ovf(ovf)
    );

    bin2bcd_seq #(.WIDTH(10), .DIGITS(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .bin(bin),
        .busy(busy3), .done(done3), .bcd(bcd3), .neg(neg3), .ovf(ovf3)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_bcd(input int v, input int digits);
        logic [31:0] r;
        int x;
        r = '0;
        x = v;
        for (int k = 0; k < digits; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Called at the negedge right after the accepting edge.
    task automatic wait_done(output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        while (!done && lat < 40) begin
            if (busy) busy_n++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic convert_check(input string tag, input logic [9:0] b, input logic sm,
                                 input logic [15:0] e_bcd, input logic e_neg, input logic e_ovf,
                                 input logic [11:0] e_bcd3, input logic e_ovf3);
        int lat, busy_n;
        @(negedge clk);
        start = 1'b1;
        bin = b;
        signed_mode = sm;
        @(negedge clk);
        start = 1'b0;
        bin = ~b;
        signed_mode = ~sm;
        wait_done(lat, busy_n);
        check({tag, "_latency"}, lat, 10);
        check({tag, "_busy_cycles"}, busy_n, 10);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_bcd"}, bcd, e_bcd);
        check({tag, "_neg"}, neg, e_neg);
        check({tag, "_ovf"}, ovf, e_ovf);
        check({tag, "_bcd3"}, bcd3, e_bcd3);
        check({tag, "_ovf3"}, ovf3, e_ovf3);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_bcd_hold"}, bcd, e_bcd);
    endtask

    initial begin
        int ndone, lat, busy_n, per, mag;
        logic exp_neg;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bcd", bcd, 0);
        check("rst_neg", neg, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;

        convert_check("u1023", 10'd1023, 1'b0, 16'h1023, 1'b0, 1'b0, 12'h023, 1'b1);
        convert_check("s200",  10'h200,  1'b1, 16'h0512, 1'b1, 1'b0, 12'h512, 1'b0);
        convert_check("s3ff",  10'h3FF,  1'b1, 16'h0001, 1'b1, 1'b0, 12'h001, 1'b0);
        convert_check("s0",    10'd0,    1'b1, 16'h0000, 1'b0, 1'b0, 12'h000, 1'b0);
        convert_check("u1000", 10'd1000, 1'b0, 16'h1000, 1'b0, 1'b0, 12'h000, 1'b1);
        convert_check("u999",  10'd999,  1'b0, 16'h0999, 1'b0, 1'b0, 12'h999, 1'b0);
        convert_check("s1ff",  10'h1FF,  1'b1, 16'h0511, 1'b0, 1'b0, 12'h511, 1'b0);
        convert_check("s3e8",  10'h3E8,  1'b1, 16'h0024, 1'b1, 1'b0, 12'h024, 1'b0);

        // Starts pulsed while busy must be ignored.
        @(negedge clk);
        start = 1'b1;
        bin = 10'd7;
        signed_mode = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            start = (i == 3 || i == 6);
            bin = 10'd999;
            if (done) begin
                ndone++;
                check("ignore_bcd", bcd, 16'h0007);
            end
        end
        start = 1'b0;
        check("ignore_done_count", ndone, 1);

        // Reset in the middle of a conversion, then restart on the first edge after release.
        @(negedge clk);
        start = 1'b1;
        bin = 10'd500;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_bcd", bcd, 0);
        check("midrst_done", done, 0);
        @(negedge clk);
        check("midrst_done_hold", done, 0);
        rst = 1'b0;
        start = 1'b1;
        bin = 10'd321;
        signed_mode = 1'b0;
        @(negedge clk);
        check("post_rst_accept", busy, 1);
        start = 1'b0;
        wait_done(lat, busy_n);
        check("post_rst_latency", lat, 10);
        check("post_rst_bcd", bcd, 16'h0321);

        // Exhaustive back-to-back sweep in both modes, start held high.
        for (int m = 0; m < 2; m++) begin
            @(negedge clk);
            start = 1'b1;
            signed_mode = m[0];
            bin = 10'd0;
            for (int i = 0; i < 1024; i++) begin
                per = 0;
                do begin
                    @(negedge clk);
                    per++;
                end while (!done && per < 40);
                exp_neg = (m == 1) && (i >= 512);
                mag = exp_neg ? 1024 - i : i;
                check("sweep_period", per, 11);
                check("sweep_bcd", bcd, ref_bcd(mag, 4));
                check("sweep_neg", neg, exp_neg);
                check("sweep_ovf", ovf, 0);
                check("sweep_bcd3", bcd3, ref_bcd(mag, 3));
                check("sweep_ovf3", ovf3, (mag >= 1000) ? 1 : 0);
                bin = 10'(i + 1);
                if (i == 1023) start = 1'b0;
            end
        end

        @(negedge clk);
        check("final_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL provide parameter WIDTH, default 10, binary input width (2..32).
REQ-002 SHALL provide parameter DIGITS, default 4, number of BCD output digits (1..10).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  conversion request, sampled on clk.
REQ-006 SHALL have port signed_mode  input  1  1 = treat bin as two's complement.
REQ-007 SHALL have port bin  input  WIDTH  binary operand, sampled with start.
REQ-008 SHALL have port busy  output  1  conversion in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse, result registers just updated.
REQ-010 SHALL have port bcd  output  4*DIGITS  result; digit k at bits [4k+3:4k], digit 0 = units.
REQ-011 SHALL have port neg  output  1  result sign (1 = negative operand).
REQ-012 SHALL have port ovf  output  1  magnitude >= 10^DIGITS.

Function
REQ-013 SHALL implement sequential shift-add-3 (double dabble), one bit per clock, states IDLE and SHIFT.
REQ-014 SHALL accept start only when busy = 0 (IDLE, including the done cycle); start while busy = 1 ignored, no effect on operation in flight.
REQ-015 SHALL, on accepting edge E0, capture magnitude: bin if signed_mode = 0 or bin[WIDTH-1] = 0, else two's-complement negation of bin as WIDTH-bit unsigned; capture sign = signed_mode & bin[WIDTH-1].
REQ-016 SHALL treat most-negative operand (e.g. 10'h200) as magnitude 2^(WIDTH-1), no error.
REQ-017 SHALL clear internal BCD scratch to zero at E0 and load a bit counter with WIDTH.
REQ-018 SHALL, at each edge E1..E_WIDTH, add 3 to every scratch digit >= 5, then shift scratch left one bit inserting next magnitude MSB.
REQ-019 SHALL set internal overflow sticky if any 1 bit is shifted out of the top digit.
REQ-020 SHALL assert busy from E0 through E_WIDTH (exactly WIDTH cycles high).
REQ-021 SHALL, at E_WIDTH, load bcd, neg, ovf with final values, drop busy, and assert done for exactly one cycle.
REQ-022 SHALL hold bcd, neg, ovf constant between done pulses; bin and signed_mode changes after E0 have no effect.
REQ-023 SHALL, on overflow, present bcd = magnitude mod 10^DIGITS with ovf = 1.
REQ-024 SHALL report zero operand as bcd = 0, neg = 0, even when signed_mode = 1.
REQ-025 SHALL allow back-to-back operation: start held high gives one result every WIDTH+1 cycles.
REQ-026 SHALL never emit a BCD digit greater than 9.

Reset
REQ-027 SHALL, while rst = 1, force state IDLE, busy = 0, done = 0, bcd = 0, neg = 0, ovf = 0, scratch and counter cleared.
REQ-028 SHALL abort any in-flight conversion on rst with no done pulse and no output update.
REQ-029 SHALL accept start on the first clock edge after rst deasserts.

Verification
REQ-030 SHALL check WIDTH=10, DIGITS=4, signed_mode=0, bin=1023, start one cycle -> busy high 10 cycles, done on cycle 10, bcd=16'h1023, neg=0, ovf=0.
REQ-031 SHALL check signed_mode=1, bin=10'h200 -> bcd=16'h0512, neg=1; bin=10'h3FF -> bcd=16'h0001, neg=1; bin=0 -> bcd=0, neg=0.
REQ-032 SHALL check start pulsed at cycles 3 and 6 after an accepted start -> single done, result of first operand only.
REQ-033 SHALL check rst asserted mid-conversion (cycle 5) -> busy=0, bcd=0 immediately, no done; fresh conversion afterwards correct.
REQ-034 SHALL check WIDTH=10, DIGITS=3, bin=1000 -> bcd=12'h000, ovf=1; bin=999 -> bcd=12'h999, ovf=0.
REQ-035 SHALL check exhaustive sweep of all 1024 operands in both modes against a reference model, start held high, done every 11 cycles.
